uart_tx_cfg: RTL and testbench

//  Next-generation UART transmitter for the serial debug/data path. Runtime-configurable frame:
//  5-8 data bits, parity none/even/odd, stop bits 1/1.5/2. Contains its own baud prescaler
//  (16x oversample tick), so the old external clk_en_i strobe is no longer needed.
//  A FIFO with a valid/ready front end allows back-to-back frames without host polling.

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_tx_cfg_if.sv | 19 +
 rtl/uart_tx_fifo.sv | 52 +++++
 rtl/uart_tx_cfg.sv | 147 ++++++++++++++
 tb/tb_uart_tx_cfg.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared encodings and helpers for the configurable UART transmitter.
// Frame options, one-hot FSM states and stop-length lookup.
package uart_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  localparam logic [1:0] STOP_1  = 2'b00;
  localparam logic [1:0] STOP_15 = 2'b01;
  localparam logic [1:0] STOP_2  = 2'b10;

  localparam logic [1:0] DATA_5 = 2'b00;
  localparam logic [1:0] DATA_6 = 2'b01;
  localparam logic [1:0] DATA_7 = 2'b10;
  localparam logic [1:0] DATA_8 = 2'b11;

  typedef enum logic [4:0] {
    S_IDLE   = 5'b00001,
    S_START  = 5'b00010,
    S_DATA   = 5'b00100,
    S_PARITY = 5'b01000,
    S_STOP   = 5'b10000
  } state_t;

  function automatic logic [5:0] stop_ticks(
    input logic [1:0] s
  );
    case (s)
      STOP_1:  stop_ticks = 6'd16;
      STOP_15: stop_ticks = 6'd24;
      default: stop_ticks = 6'd32;
    endcase
  endfunction

  function automatic logic [7:0] data_mask(
    input logic [1:0] d
  );
    data_mask = 8'hFF >> (2'd3 - d);
  endfunction

endpackage

// File: rtl/uart_tx_cfg_if.sv
// Host-side byte handshake of the UART transmitter.
// The host (master) offers bytes, the transmitter (slave) accepts.
interface uart_tx_cfg_if;
  logic [7:0] tx_data_i;
  logic       tx_valid_i;
  logic       tx_ready_o;

  modport master (
    output tx_data_i,
    output tx_valid_i,
    input  tx_ready_o
  );

  modport slave (
    input  tx_data_i,
    input  tx_valid_i,
    output tx_ready_o
  );
endinterface

// File: rtl/uart_tx_fifo.sv
// Small synchronous byte FIFO; full/empty come from the level count.
// Requests against full/empty are ignored.
module uart_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          reset_n_i,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic          wr;
  logic          rd;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign dout  = mem[rptr];

  always_ff @(posedge clk_i) begin
    if (wr) mem[wptr] <= din;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (wr) wptr <= wptr + 1'b1;
      if (rd) rptr <= rptr + 1'b1;
      unique case ({wr, rd})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// UART transmitter with runtime frame config, built-in 16x prescaler
// and a byte FIFO in front of the shift FSM.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV    = 27,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       reset_n_i,
  uart_tx_cfg_if.slave tx,
  input  logic [1:0] cfg_data_i,
  input  logic [1:0] cfg_parity_i,
  input  logic [1:0] cfg_stop_i,
  output logic       uart_tx_o,
  output logic       busy_o,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level_o
);

  localparam int PW = $clog2(CLK_DIV + 1);

  state_t        state;
  state_t        nstate;
  logic [PW-1:0] pcnt;
  logic [5:0]    tcnt;
  logic [5:0]    tlim;
  logic [2:0]    bcnt;
  logic [7:0]    sh;
  logic [7:0]    fdout;
  logic [7:0]    fbyte;
  logic [1:0]    dcfg_q;
  logic [1:0]    stop_q;
  logic          par_q;
  logic          par_en_q;
  logic          fempty;
  logic          ffull;
  logic          pop;
  logic          tick;
  logic          bit_end;
  logic          line;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i     (clk_i),
    .reset_n_i (reset_n_i),
    .push      (tx.tx_valid_i),
    .din       (tx.tx_data_i),
    .pop       (pop),
    .dout      (fdout),
    .full      (ffull),
    .empty     (fempty),
    .level     (fifo_level_o)
  );

  assign tx.tx_ready_o = !ffull;
  assign busy_o  = (state != S_IDLE)
                || (fifo_level_o != '0);

  assign tick = (state != S_IDLE)
             && (pcnt == PW'(CLK_DIV - 1));
  assign tlim = (state == S_STOP)
              ? stop_ticks(stop_q) : 6'd16;
  assign bit_end = tick && (tcnt == tlim - 6'd1);
  assign fbyte = fdout & data_mask(cfg_data_i);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state <= S_IDLE;
    else            state <= nstate;
  end

  always_comb begin
    nstate = state;
    pop    = 1'b0;
    line   = 1'b1;
    unique case (1'b1)
      (state == S_IDLE): begin
        if (!fempty) begin
          pop    = 1'b1;
          nstate = S_START;
        end
      end
      (state == S_START): begin
        line = 1'b0;
        if (bit_end) nstate = S_DATA;
      end
      (state == S_DATA): begin
        line = sh[0];
        if (bit_end && bcnt == 3'd4 + 3'(dcfg_q))
          nstate = par_en_q ? S_PARITY : S_STOP;
      end
      (state == S_PARITY): begin
        line = par_q;
        if (bit_end) nstate = S_STOP;
      end
      (state == S_STOP): begin
        if (bit_end) begin
          if (!fempty) begin
            pop    = 1'b1;
            nstate = S_START;
          end else begin
            nstate = S_IDLE;
          end
        end
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Frame config and parity are captured at the pop only.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      uart_tx_o <= 1'b1;
      pcnt      <= '0;
      tcnt      <= '0;
      bcnt      <= '0;
      sh        <= '0;
      par_q     <= 1'b0;
      par_en_q  <= 1'b0;
      stop_q    <= STOP_1;
      dcfg_q    <= DATA_8;
    end else begin
      uart_tx_o <= line;
      if (pop) begin
        pcnt     <= '0;
        tcnt     <= '0;
        bcnt     <= '0;
        sh       <= fbyte;
        par_q    <= (^fbyte)
                  ^ (cfg_parity_i == PAR_ODD);
        par_en_q <= (cfg_parity_i == PAR_EVEN)
                 || (cfg_parity_i == PAR_ODD);
        stop_q   <= cfg_stop_i;
        dcfg_q   <= cfg_data_i;
      end else begin
        if (state == S_IDLE || tick) pcnt <= '0;
        else                         pcnt <= pcnt + 1'b1;
        if (tick) tcnt <= bit_end ? 6'd0 : tcnt + 6'd1;
        if (bit_end && state == S_DATA) begin
          sh   <= sh >> 1;
          bcnt <= bcnt + 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: directed frames, a scoreboard queue and a
// line monitor that decodes each frame at mid-bit (CLK_DIV=2).
module tb_uart_tx_cfg;

  typedef struct {
    logic [7:0] data;
    int         n;
    bit         has_par;
    bit         par;
    int         stop_cyc;
  } exp_t;

  logic       clk;
  logic       reset_n;
  logic [1:0] cfg_data;
  logic [1:0] cfg_par;
  logic [1:0] cfg_stop;
  logic       uart_tx;
  logic       busy;
  logic [2:0] level;

  int   pass_cnt;
  int   total_cnt;
  int   cyc;
  int   push_cyc;
  int   b2b_cnt;
  int   peak;
  int   viol;
  exp_t exp_q[$];

  uart_tx_cfg_if bus ();

  uart_tx_cfg #(
    .CLK_DIV    (2),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i        (clk),
    .reset_n_i    (reset_n),
    .tx           (bus),
    .cfg_data_i   (cfg_data),
    .cfg_parity_i (cfg_par),
    .cfg_stop_i   (cfg_stop),
    .uart_tx_o    (uart_tx),
    .busy_o       (busy),
    .fifo_level_o (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc  = 0;
    peak = 0;
    viol = 0;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (int'(level) > peak) peak <= int'(level);
    if ((level == 3'd4) == bus.tx_ready_o) viol <= viol + 1;
  end

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] want);
    total_cnt++;
    if (got === want) pass_cnt++;
    else $display("FAIL %s: got %0h want %0h", nm, got, want);
  endtask

  task automatic wn(input int n, inout bit ab);
    for (int i = 0; i < n; i++) begin
      if (ab) return;
      @(negedge clk);
      if (!reset_n) ab = 1'b1;
    end
  endtask

  task automatic push(input logic [7:0] d, input bit p);
    exp_t e;
    int   w;
    bus.tx_data_i  = d;
    bus.tx_valid_i = 1'b1;
    w = 0;
    while (!bus.tx_ready_o && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (!bus.tx_ready_o) chk("push_timeout", 32'(bus.tx_ready_o), 1);
    @(posedge clk);
    #1;
    push_cyc   = cyc;
    e.n        = 5 + int'(cfg_data);
    e.data     = d & (8'hFF >> (3 - int'(cfg_data)));
    e.has_par  = (cfg_par == 2'b01) || (cfg_par == 2'b10);
    e.par      = p;
    e.stop_cyc = (cfg_stop == 2'b00) ? 32
               : (cfg_stop == 2'b01) ? 48 : 64;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (!busy) break;
    end
    if (busy) chk("idle_timeout", 32'(busy), 0);
    repeat (8) @(negedge clk);
  endtask

  task automatic wait_cyc(input int target);
    for (int k = 0; k < 5000; k++) begin
      if (cyc >= target) break;
      @(negedge clk);
    end
    chk("cyc_reach", cyc, target);
  endtask

  task automatic set_cfg(input logic [1:0] d,
                         input logic [1:0] p,
                         input logic [1:0] s);
    cfg_data = d;
    cfg_par  = p;
    cfg_stop = s;
  endtask

  // Line monitor: decodes frames and pops the scoreboard.
  initial begin : mon
    exp_t       e;
    logic [7:0] got;
    bit         ab;
    bit         prev;
    bit         chained;
    bit         stop_ok;
    prev    = 1'b1;
    chained = 1'b0;
    b2b_cnt = 0;
    forever begin
      if (!chained) begin
        @(negedge clk);
        if (!(reset_n && prev && !uart_tx)) begin
          prev = uart_tx;
          continue;
        end
      end
      chained = 1'b0;
      ab      = 1'b0;
      if (exp_q.size() == 0) begin
        chk("unexpected_frame", 32'(exp_q.size()), 1);
        prev = 1'b0;
        continue;
      end
      e = exp_q.pop_front();
      wn(16, ab);
      if (!ab) chk("start_bit", 32'(uart_tx), 0);
      got = '0;
      for (int i = 0; i < e.n; i++) begin
        wn(32, ab);
        if (!ab) got[i] = uart_tx;
      end
      if (!ab) chk("data", 32'(got), 32'(e.data));
      if (e.has_par) begin
        wn(32, ab);
        if (!ab) chk("parity", 32'(uart_tx), 32'(e.par));
      end
      wn(16, ab);
      stop_ok = uart_tx;
      for (int j = 1; j < e.stop_cyc; j++) begin
        wn(1, ab);
        if (!uart_tx) stop_ok = 1'b0;
      end
      wn(1, ab);
      if (!ab) begin
        chk("stop_len", 32'(stop_ok), 1);
        if (!uart_tx) begin
          chained = 1'b1;
          b2b_cnt++;
        end
      end
      prev = uart_tx;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin : main
    int lo;
    int bz;
    int b0;
    int ca;
    pass_cnt       = 0;
    total_cnt      = 0;
    reset_n        = 1'b0;
    bus.tx_data_i  = '0;
    bus.tx_valid_i = 1'b0;
    set_cfg(2'b11, 2'b00, 2'b00);
    repeat (3) @(negedge clk);
    chk("rst_line", 32'(uart_tx), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_ready", 32'(bus.tx_ready_o), 1);
    chk("rst_level", 32'(level), 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 8N1 0xA5: latency and busy fall
    push(8'hA5, 1'b0);
    bus.tx_valid_i = 1'b0;
    lo = -1;
    bz = -1;
    for (int k = 0; k < 400 && bz < 0; k++) begin
      @(negedge clk);
      if (lo < 0 && !uart_tx) lo = cyc - push_cyc;
      if (!busy) bz = cyc - push_cyc;
    end
    chk("latency", lo, 2);
    chk("busy_fall", bz, 321);
    wait_idle();

    // 7E2 0xFF, then 5O1 0x03
    set_cfg(2'b10, 2'b01, 2'b10);
    push(8'hFF, 1'b1);
    bus.tx_valid_i = 1'b0;
    wait_idle();
    set_cfg(2'b00, 2'b10, 2'b00);
    push(8'h03, 1'b1);
    bus.tx_valid_i = 1'b0;
    wait_idle();

    // 8N1.5 0x00, cfg changed to 5N1 mid-frame
    set_cfg(2'b11, 2'b00, 2'b01);
    push(8'h00, 1'b0);
    bus.tx_valid_i = 1'b0;
    repeat (100) @(negedge clk);
    set_cfg(2'b00, 2'b00, 2'b00);
    push(8'h15, 1'b0);
    bus.tx_valid_i = 1'b0;
    wait_idle();

    // 6-byte burst, 8N1, valid held
    set_cfg(2'b11, 2'b00, 2'b00);
    b0 = b2b_cnt;
    for (int i = 1; i <= 6; i++) push(8'(i), 1'b0);
    bus.tx_valid_i = 1'b0;
    wait_idle();
    chk("level_peak", peak, 4);
    chk("ready_rule", viol, 0);
    chk("b2b_frames", b2b_cnt - b0, 5);

    // reset in mid data bit 3 of 0x33
    push(8'h33, 1'b0);
    bus.tx_valid_i = 1'b0;
    wait_cyc(push_cyc + 150);
    chk("pre_rst_line", 32'(uart_tx), 0);
    reset_n = 1'b0;
    #1;
    chk("arst_line", 32'(uart_tx), 1);
    chk("arst_level", 32'(level), 0);
    chk("arst_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push(8'h5A, 1'b0);
    bus.tx_valid_i = 1'b0;
    wait_idle();

    // push on pop edges with level=1, 6O1
    set_cfg(2'b01, 2'b10, 2'b00);
    push(8'hC3, 1'b1);
    ca = push_cyc;
    push(8'h0F, 1'b1);
    bus.tx_valid_i = 1'b0;
    chk("pp1_edge", push_cyc, ca + 1);
    @(negedge clk);
    chk("pp1_level", 32'(level), 1);
    wait_cyc(ca + 288);
    push(8'h2A, 1'b0);
    bus.tx_valid_i = 1'b0;
    chk("pp2_edge", push_cyc, ca + 289);
    @(negedge clk);
    chk("pp2_level", 32'(level), 1);
    wait_idle();

    chk("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
